// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C register slave.
package i2c_pkg;

    localparam logic        ACK       = 1'b0;
    localparam int unsigned BYTE_BITS = 8;
    localparam int unsigned CNT_W     = 4;

    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WR_MSB, WR_MSB_ACK,
        WR_LSB, WR_LSB_ACK, RD_MSB, RD_MSB_ACK, RD_LSB, RD_LSB_ACK
    } state_e;

    // Acknowledge slot that follows each byte-transfer state.
    function automatic state_e ack_state(state_e s);
        case (s)
            ADDR:    return ADDR_ACK;
            PTR:     return PTR_ACK;
            WR_MSB:  return WR_MSB_ACK;
            WR_LSB:  return WR_LSB_ACK;
            RD_MSB:  return RD_MSB_ACK;
            RD_LSB:  return RD_LSB_ACK;
            default: return IDLE;
        endcase
    endfunction

endpackage

// File: rtl/i2c_sync_edge.sv
// Multi-flop synchronizer with rise/fall detection; idles high out of reset.
module i2c_sync_edge #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise_c,
    output logic fall_c
);

    logic [SYNC_STAGES:0] sync_q;
    logic [SYNC_STAGES:0] sync_d;

    always_comb sync_d = {sync_q[SYNC_STAGES-1:0], din};

    always_ff @(posedge clk) begin
        if (!rst) sync_q <= '1;
        else      sync_q <= sync_d;
    end

    assign level  = sync_q[SYNC_STAGES-1];
    assign rise_c =  sync_q[SYNC_STAGES-1] & ~sync_q[SYNC_STAGES];
    assign fall_c = ~sync_q[SYNC_STAGES-1] &  sync_q[SYNC_STAGES];

endmodule

// File: rtl/i2c_slave.sv
// I2C slave with an 8-bit pointer register and a 16-bit data word (MSB first).
module i2c_slave
    import i2c_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        scl,
    inout  wire         sda,
    input  logic [6:0]  slave_addr,
    input  logic [15:0] data_out,
    output logic [15:0] data_in,
    output logic [7:0]  pointer_in,
    input  logic [7:0]  pointer_out
);

    logic scl_s, scl_rise_c, scl_fall_c;
    logic sda_s, sda_rise_c, sda_fall_c;

    i2c_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_scl (
        .clk(clk), .rst(rst), .din(scl),
        .level(scl_s), .rise_c(scl_rise_c), .fall_c(scl_fall_c)
    );

    i2c_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sda (
        .clk(clk), .rst(rst), .din(sda),
        .level(sda_s), .rise_c(sda_rise_c), .fall_c(sda_fall_c)
    );

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [BYTE_BITS-2:0] shift_q, shift_d;
    logic [15:0]        tx_q, tx_d;
    logic [7:0]         msb_q, msb_d;
    logic               sda_oe_q, sda_oe_d;
    logic               rw_q, rw_d;
    logic [15:0]        data_in_q, data_in_d;
    logic [7:0]         pointer_q, pointer_d;

    logic       start_c, stop_c, last_bit_c, byte_done_c;
    logic [7:0] byte_c;

    assign start_c     = sda_fall_c & scl_s;
    assign stop_c      = sda_rise_c & scl_s;
    assign byte_c      = {shift_q, sda_s};
    assign last_bit_c  = (bit_cnt_q == CNT_W'(BYTE_BITS - 1));
    assign byte_done_c = (bit_cnt_q == CNT_W'(BYTE_BITS));

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        tx_d      = tx_q;
        msb_d     = msb_q;
        sda_oe_d  = sda_oe_q;
        rw_d      = rw_q;
        data_in_d = data_in_q;
        pointer_d = pointer_q;

        if (stop_c) begin
            state_d   = IDLE;
            sda_oe_d  = 1'b0;
            bit_cnt_d = '0;
        end else if (start_c) begin
            state_d   = ADDR;
            sda_oe_d  = 1'b0;
            bit_cnt_d = '0;
        end else begin
            case (state_q)
                IDLE: ;
                ADDR, PTR, WR_MSB, WR_LSB: begin
                    if (scl_rise_c) begin
                        shift_d   = byte_c[BYTE_BITS-2:0];
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                        // Registers commit only on a complete 8th bit.
                        if (last_bit_c) begin
                            case (state_q)
                                ADDR: begin
                                    rw_d = byte_c[0];
                                    if (byte_c[7:1] != slave_addr) state_d = IDLE;
                                end
                                PTR:     pointer_d = byte_c;
                                WR_MSB:  msb_d     = byte_c;
                                default: data_in_d = {msb_q, byte_c};
                            endcase
                        end
                    end else if (scl_fall_c && byte_done_c) begin
                        state_d   = ack_state(state_q);
                        sda_oe_d  = 1'b1;
                        bit_cnt_d = '0;
                        if (state_q == ADDR) tx_d = data_out;
                    end
                end
                ADDR_ACK, PTR_ACK, WR_MSB_ACK, WR_LSB_ACK: begin
                    if (scl_fall_c) begin
                        sda_oe_d  = 1'b0;
                        bit_cnt_d = '0;
                        case (state_q)
                            ADDR_ACK: begin
                                state_d  = rw_q ? RD_MSB : PTR;
                                sda_oe_d = rw_q & ~tx_q[15];
                            end
                            PTR_ACK:    state_d = WR_MSB;
                            WR_MSB_ACK: state_d = WR_LSB;
                            default:    state_d = WR_MSB;
                        endcase
                    end
                end
                RD_MSB, RD_LSB: begin
                    if (scl_rise_c) begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end else if (scl_fall_c) begin
                        if (byte_done_c) begin
                            state_d   = ack_state(state_q);
                            sda_oe_d  = 1'b0;
                            bit_cnt_d = '0;
                        end else begin
                            tx_d     = {tx_q[14:0], 1'b0};
                            sda_oe_d = ~tx_q[14];
                        end
                    end
                end
                RD_MSB_ACK, RD_LSB_ACK: begin
                    // Master's ACK/NACK bit is captured in shift_q[0].
                    if (scl_rise_c) begin
                        shift_d = byte_c[BYTE_BITS-2:0];
                    end else if (scl_fall_c) begin
                        if (shift_q[0] != ACK) begin
                            state_d  = IDLE;
                            sda_oe_d = 1'b0;
                        end else if (state_q == RD_MSB_ACK) begin
                            state_d  = RD_LSB;
                            tx_d     = {tx_q[14:0], 1'b0};
                            sda_oe_d = ~tx_q[14];
                        end else begin
                            state_d  = RD_MSB;
                            tx_d     = data_out;
                            sda_oe_d = ~data_out[15];
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            tx_q      <= '0;
            msb_q     <= '0;
            sda_oe_q  <= 1'b0;
            rw_q      <= 1'b0;
            data_in_q <= '0;
            pointer_q <= pointer_out;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
            msb_q     <= msb_d;
            sda_oe_q  <= sda_oe_d;
            rw_q      <= rw_d;
            data_in_q <= data_in_d;
            pointer_q <= pointer_d;
        end
    end

    assign sda        = sda_oe_q ? ACK : 1'bz;
    assign data_in    = data_in_q;
    assign pointer_in = pointer_q;

endmodule

// File: tb/tb_i2c_slave.sv
// Randomized I2C master driving i2c_slave, checked by a transaction-level model and scoreboard.
module tb_i2c_slave;

    localparam int Q = 6;  // clk cycles per quarter scl period

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        scl = 1'b1;
    logic        m_sda_low = 1'b0;
    wire         sda;
    logic [6:0]  slave_addr;
    logic [15:0] data_out;
    logic [15:0] data_in;
    logic [7:0]  pointer_in;
    logic [7:0]  pointer_out;

    assign sda = m_sda_low ? 1'b0 : 1'bz;
    pullup (sda);

    always #5 clk = ~clk;

    i2c_slave #(.SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .scl(scl), .sda(sda),
        .slave_addr(slave_addr), .data_out(data_out), .data_in(data_in),
        .pointer_in(pointer_in), .pointer_out(pointer_out)
    );

    typedef struct packed {
        logic       kind;  // 0: ack bit seen by master, 1: byte read by master
        logic [7:0] val;
    } bus_t;

    bus_t        exp_bus[$];
    bus_t        obs_bus[$];
    logic [23:0] exp_reg[$];
    logic [23:0] reg_prev;
    bus_t        mon_o, mon_e;
    logic        mon_en = 1'b0;
    int          checks = 0;
    int          passes = 0;

    logic [7:0]  m_ptr;
    logic [15:0] m_data;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Bus scoreboard: pair each master observation with the model's prediction.
    always @(negedge clk) begin
        if (obs_bus.size() > 0) begin
            mon_o = obs_bus.pop_front();
            if (exp_bus.size() == 0) begin
                checks++;
                $display("FAIL bus_unexpected: got 0x%0h expected none", mon_o);
            end else begin
                mon_e = exp_bus.pop_front();
                chk(mon_e.kind ? "read_byte" : "ack_bit", 32'(mon_o), 32'(mon_e));
            end
        end
    end

    // Register scoreboard: every change of {pointer_in,data_in} must be predicted.
    always @(negedge clk) begin
        if ({pointer_in, data_in} !== reg_prev) begin
            if (mon_en) begin
                if (exp_reg.size() == 0) begin
                    checks++;
                    $display("FAIL reg_unexpected: got 0x%0h expected none", {pointer_in, data_in});
                end else begin
                    chk("reg_update", 32'({pointer_in, data_in}), 32'(exp_reg.pop_front()));
                end
            end
            reg_prev = {pointer_in, data_in};
        end
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic model_set(logic [7:0] p, logic [15:0] d);
        if ({p, d} != {m_ptr, m_data}) begin
            exp_reg.push_back({p, d});
            m_ptr  = p;
            m_data = d;
        end
    endtask

    function automatic logic addr_hit(logic [7:0] ab);
        return ab[7:1] == slave_addr;
    endfunction

    task automatic qw();
        repeat (Q) @(negedge clk);
    endtask

    task automatic bus_start();
        m_sda_low = 1'b0; qw(); scl = 1'b1; qw(); m_sda_low = 1'b1; qw(); scl = 1'b0; qw();
    endtask

    task automatic bus_stop();
        m_sda_low = 1'b1; qw(); scl = 1'b1; qw(); m_sda_low = 1'b0; qw();
    endtask

    task automatic wbit(logic b);
        m_sda_low = ~b; qw(); scl = 1'b1; qw(); qw(); scl = 1'b0; qw();
    endtask

    task automatic rbit(output logic b);
        m_sda_low = 1'b0; qw(); scl = 1'b1; qw(); b = sda; qw(); scl = 1'b0; qw();
    endtask

    task automatic send_byte(logic [7:0] b, logic exp_ack);
        logic a;
        exp_bus.push_back({1'b0, 7'b0, exp_ack});
        for (int i = 7; i >= 0; i--) wbit(b[i]);
        rbit(a);
        obs_bus.push_back({1'b0, 7'b0, a});
    endtask

    task automatic recv_byte(logic [7:0] exp_b, logic m_ack);
        logic [7:0] b;
        exp_bus.push_back({1'b1, exp_b});
        for (int i = 7; i >= 0; i--) rbit(b[i]);
        obs_bus.push_back({1'b1, b});
        wbit(m_ack);
    endtask

    task automatic write_txn(logic [7:0] ab, logic [7:0] ptr, logic [15:0] w [4], int n, logic do_stop);
        logic hit;
        hit = addr_hit(ab);
        bus_start();
        send_byte(ab, ~hit);
        if (hit) model_set(ptr, m_data);
        send_byte(ptr, ~hit);
        for (int i = 0; i < n; i++) begin
            send_byte(w[i][15:8], ~hit);
            if (hit) model_set(m_ptr, w[i]);
            send_byte(w[i][7:0], ~hit);
        end
        if (do_stop) bus_stop();
    endtask

    task automatic read_txn(logic [7:0] ab, logic [15:0] w [4], int n, logic nack_msb);
        logic hit;
        logic last;
        hit = addr_hit(ab);
        data_out = w[0];
        bus_start();
        send_byte(ab, ~hit);
        if (hit) begin
            for (int i = 0; i < n; i++) begin
                last = (i == n - 1);
                recv_byte(w[i][15:8], last & nack_msb);
                if (last & nack_msb) break;
                if (!last) data_out = w[i+1];
                recv_byte(w[i][7:0], last);
            end
            chk("sda_released_after_nack", 32'(sda), 32'(1));
        end
        bus_stop();
    endtask

    task automatic abort_write(logic [7:0] ptr, logic [7:0] msb, logic [3:0] bits);
        bus_start();
        send_byte({slave_addr, 1'b0}, 1'b0);
        model_set(ptr, m_data);
        send_byte(ptr, 1'b0);
        send_byte(msb, 1'b0);
        for (int i = 3; i >= 0; i--) wbit(bits[i]);
        bus_stop();
    endtask

    initial begin
        logic [15:0] w [4];
        logic        b;
        int          n;
        int          kind;

        slave_addr  = 7'h40;
        pointer_out = 8'h09;
        data_out    = 16'h0000;
        repeat (4) @(negedge clk);
        chk("reset_data_in", 32'(data_in), 32'h0000);
        chk("reset_pointer_in", 32'(pointer_in), 32'h09);
        chk("reset_sda", 32'(sda), 32'(1));
        m_ptr  = 8'h09;
        m_data = 16'h0000;
        mon_en = 1'b1;
        rst    = 1'b1;
        pointer_out = 8'h00;
        qw();

        w = '{16'h1234, 16'h0, 16'h0, 16'h0};
        write_txn(8'h80, 8'h05, w, 1, 1'b1);
        chk("write_pointer_in", 32'(pointer_in), 32'h05);
        chk("write_data_in", 32'(data_in), 32'h1234);

        w = '{16'h0091, 16'h0, 16'h0, 16'h0};
        read_txn(8'h81, w, 1, 1'b0);

        write_txn(8'h82, 8'h05, w, 0, 1'b1);
        chk("wrong_addr_pointer_in", 32'(pointer_in), 32'h05);

        write_txn(8'h80, 8'h07, w, 0, 1'b0);
        w = '{16'hABCD, 16'h0, 16'h0, 16'h0};
        read_txn(8'h81, w, 1, 1'b0);
        chk("sr_pointer_in", 32'(pointer_in), 32'h07);

        abort_write(8'h07, 8'h55, 4'b1010);
        chk("abort_data_in", 32'(data_in), 32'h1234);

        // Reset while the slave is driving a 0 data bit.
        data_out    = 16'h0000;
        pointer_out = 8'h22;
        bus_start();
        send_byte(8'h81, 1'b0);
        for (int i = 0; i < 3; i++) rbit(b);
        chk("read_driving_low", 32'(sda), 32'(0));
        model_set(8'h22, 16'h0000);
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1;
        chk("reset_releases_sda", 32'(sda), 32'(1));
        rst = 1'b1;
        qw();
        w = '{16'h5A3C, 16'hC001, 16'h0, 16'h0};
        read_txn(8'h81, w, 2, 1'b0);

        for (int t = 0; t < 16; t++) begin
            slave_addr = 7'($urandom);
            for (int k = 0; k < 4; k++) w[k] = 16'($urandom);
            n    = $urandom_range(1, 2);
            kind = $urandom_range(0, 4);
            case (kind)
                0: write_txn({slave_addr, 1'b0}, 8'($urandom), w, n, 1'b1);
                1: read_txn({slave_addr, 1'b1}, w, n, 1'($urandom));
                2: begin
                    write_txn({slave_addr, 1'b0}, 8'($urandom), w, 0, 1'b0);
                    read_txn({slave_addr, 1'b1}, w, n, 1'b0);
                end
                3: write_txn({slave_addr ^ 7'($urandom_range(1, 127)), 1'b0}, 8'($urandom), w, n, 1'b1);
                default: abort_write(8'($urandom), 8'($urandom), 4'($urandom));
            endcase
            qw();
        end

        repeat (4) qw();
        chk("exp_bus_drained", 32'(exp_bus.size()), 32'(0));
        chk("exp_reg_drained", 32'(exp_reg.size()), 32'(0));
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
